btn_conditioner: RTL
====================

Name: btn_conditioner

Overview:
- Front-end conditioner for one push-button. Replaces the plain 3-FF delay-line debouncer on the increment-button paths.
- Synchronises the raw pad into clk_100MHz and filters bounce with a stable-count debouncer.
- Emits a one-cycle press pulse, then auto-repeat pulses while the button is held, so holding btnR/btnL slews minutes/hours.
- Sits directly upstream of the inc_minutes/inc_hours OR gates that feed the minutes and hours counters; one instance per button.

Parameters:
DB_CYCLES, 1_000_000, consecutive stable cycles required to accept a level change (10 ms at 100 MHz); legal range >= 2.
HOLD_CYCLES, 50_000_000, cycles from accepted press to first auto-repeat pulse (500 ms); legal range >= 2.
REPEAT_CYCLES, 20_000_000, cycles between successive auto-repeat pulses (200 ms); legal range >= 2.
REPEAT_EN, 1, 1 enables auto-repeat; 0 gives a single pulse per press.

Ports:
clk_100MHz  input  1  system clock
reset_n  input  1  asynchronous active-low reset
btn_in  input  1  raw, asynchronous, active-high button pad
btn_level  output  1  debounced button level
btn_pulse  output  1  one-cycle pulse on accepted press and on each auto-repeat
btn_release  output  1  one-cycle pulse on accepted release
repeat_active  output  1  high while in the REPEAT state

Behaviour:
- Reset:
  - Interface: one clock, clk_100MHz; reset_n is asynchronous, active-low.
  - Assertion immediately clears the sync FFs, the debounce counter, the timer, btn_level, btn_pulse, btn_release and repeat_active, and sets state to IDLE.
  - Deassertion is used as-is; it is synchronous to clk_100MHz at top level.
- Synchroniser: two FFs; s = second stage. No logic on the first stage.
- Debounce filter:
  - cnt, width $clog2(DB_CYCLES), counts the consecutive edges at which s != btn_level.
  - At an edge where s == btn_level: cnt <= 0.
  - At an edge where s != btn_level and cnt == DB_CYCLES-1: btn_level <= s and cnt <= 0.
  - Otherwise: cnt increments.
- Latency: btn_in first sampled high at edge 1 and held stable gives btn_level high after edge DB_CYCLES+2. Release has the same latency.
- Glitches: any pulse or bounce shorter than DB_CYCLES cycles, as seen at s, never changes btn_level.
- rise/fall are internal, combinational: the same-edge update condition with s=1 or s=0 respectively.
- FSM states IDLE, HOLD, REPEAT, with timer width $clog2(max(HOLD_CYCLES, REPEAT_CYCLES)):
  - IDLE: on rise, go to HOLD, timer <= 0, btn_pulse <= 1 on the same edge that btn_level rises.
  - HOLD: timer increments each cycle. When timer == HOLD_CYCLES-1 and REPEAT_EN=1: btn_pulse <= 1, timer <= 0, go to REPEAT. With REPEAT_EN=0, stay in HOLD and saturate the timer; no pulse.
  - REPEAT: when timer == REPEAT_CYCLES-1: btn_pulse <= 1, timer <= 0. Otherwise timer increments. repeat_active = 1 in this state.
  - Any state on fall: go to IDLE, timer <= 0, btn_release <= 1 on the same edge; no btn_pulse.
- Simultaneous fall and timer terminal in the same cycle: fall wins; btn_release = 1, btn_pulse = 0.
- btn_pulse and btn_release are registered, high for exactly one cycle, and never high together.
- All outputs are registered; there are no combinational paths from btn_in.
- Reset mid-hold or mid-repeat: outputs go low immediately. After release of reset, a still-pressed button must re-qualify through DB_CYCLES and then produces a fresh press pulse.

Decomposition:
- Shared clock package holds:
  - state enum btn_state_t {IDLE, HOLD, REPEAT};
  - default cycle constants DB_10MS, HOLD_500MS, REPEAT_200MS for CLK_HZ = 100_000_000.
- One natural sub-module, debounce_filter (synchroniser + stable counter; outputs btn_level and the rise/fall strobes).
- The repeat FSM lives in btn_conditioner.

Test Plan:
All scenarios use DB_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=5.
1. btn_in high for 3 cycles, then low -> btn_level, btn_pulse and btn_release stay 0 throughout.
2. btn_in toggles every 2 cycles for 20 cycles, then stays high (first stable sample at edge E) -> exactly one btn_pulse, with btn_level rising on the same edge at E+5; no earlier pulses.
3. Clean press sampled at edge 1, held 40 cycles -> btn_pulse after edges 6, 16, 21, 26, 31, 36; repeat_active high from edge 16.
4. Same press with REPEAT_EN=0 -> single btn_pulse after edge 6; repeat_active never set.
5. Release timed so fall coincides with REPEAT timer == 4 -> btn_release = 1, btn_pulse = 0 that cycle, state IDLE; no further pulses.
6. reset_n pulled low mid-REPEAT with btn_in held, released 3 cycles later -> all outputs 0 immediately; new btn_pulse exactly DB_CYCLES+2 edges after reset release.

Source files
------------

// File: rtl/btn_conditioner_pkg.sv
// Shared types and default timing constants for the push-button conditioner.
package btn_conditioner_pkg;

    // Repeat FSM states
    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } btn_state_t;

    // Default cycle counts for a 100 MHz system clock
    localparam int unsigned CLK_HZ       = 100_000_000;
    localparam int unsigned DB_10MS      = CLK_HZ / 100;
    localparam int unsigned HOLD_500MS   = CLK_HZ / 2;
    localparam int unsigned REPEAT_200MS = CLK_HZ / 5;

    // Larger of two counts, used to size the shared hold/repeat timer
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_conditioner_debounce_filter.sv
// Two-FF synchroniser followed by a stable-count debouncer. The accepted level
// only changes after DB_CYCLES consecutive samples that disagree with it.
module debounce_filter
    import btn_conditioner_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_10MS
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CntW = $clog2(DB_CYCLES);

    logic [1:0]      sync_q;
    logic            s;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            update;

    assign s = sync_q[1];

    // Synchroniser: plain shift, nothing between the stages
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn_i};
        end
    end

    // Stable counter: restart on agreement, accept the new level on the terminal count
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        update  = 1'b0;
        if (s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntW'(DB_CYCLES - 1)) begin
            level_d = s;
            cnt_d   = '0;
            update  = 1'b1;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Debounce state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;
    // Strobes are valid in the cycle before level_o changes so the FSM can
    // register its pulse on the same edge
    assign rise_o  = update & s;
    assign fall_o  = update & ~s;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button front end: debounced level, press pulse, auto-repeat pulses while
// held and a release pulse. All outputs are registered.
module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int unsigned DB_CYCLES     = DB_10MS,
    parameter int unsigned HOLD_CYCLES   = HOLD_500MS,
    parameter int unsigned REPEAT_CYCLES = REPEAT_200MS,
    parameter int unsigned REPEAT_EN     = 1
) (
    input  logic clk_100MHz,
    input  logic reset_n,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_pulse,
    output logic btn_release,
    output logic repeat_active
);

    localparam int unsigned TmrW = $clog2(max_u(HOLD_CYCLES, REPEAT_CYCLES));

    logic            rise, fall;
    btn_state_t      state_q, state_d;
    logic [TmrW-1:0] timer_q, timer_d;
    logic            pulse_q, pulse_d;
    logic            release_q, release_d;
    logic            repeat_q;

    debounce_filter #(
        .DB_CYCLES(DB_CYCLES)
    ) u_filter (
        .clk_i  (clk_100MHz),
        .rst_ni (reset_n),
        .btn_i  (btn_in),
        .level_o(btn_level),
        .rise_o (rise),
        .fall_o (fall)
    );

    // Next-state: a fall always wins over a coincident timer terminal count
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        pulse_d   = 1'b0;
        release_d = 1'b0;
        if (fall) begin
            state_d   = IDLE;
            timer_d   = '0;
            release_d = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d = HOLD;
                        timer_d = '0;
                        pulse_d = 1'b1;
                    end
                end
                HOLD: begin
                    if (timer_q == TmrW'(HOLD_CYCLES - 1)) begin
                        // Without auto-repeat the timer just parks at terminal
                        if (REPEAT_EN != 0) begin
                            state_d = REPEAT;
                            timer_d = '0;
                            pulse_d = 1'b1;
                        end
                    end else begin
                        timer_d = timer_q + TmrW'(1);
                    end
                end
                REPEAT: begin
                    if (timer_q == TmrW'(REPEAT_CYCLES - 1)) begin
                        timer_d = '0;
                        pulse_d = 1'b1;
                    end else begin
                        timer_d = timer_q + TmrW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            endcase
        end
    end

    // FSM and output registers
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            pulse_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pulse_q   <= pulse_d;
            release_q <= release_d;
            repeat_q  <= (state_d == REPEAT);
        end
    end

    assign btn_pulse     = pulse_q;
    assign btn_release   = release_q;
    assign repeat_active = repeat_q;

endmodule
